button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_cond_pkg.sv | 26 ++
 rtl/button_conditioner_if.sv | 31 +++
 rtl/button_debounce.sv | 151 +++++++++++++++
 rtl/button_conditioner.sv | 72 +++++++
 4 files changed

// File: rtl/button_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_cond_pkg
// Description : Shared types and constants for the button conditioner: the
//               per-button debounce FSM state encoding, the counter width and
//               a saturating-increment helper used by every counter.
// Revision    : 1.0 - initial release
// ============================================================================
package button_cond_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage : button_cond_pkg
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Button-side and display-side signal bundle of the button
//               conditioner.
//   btn_plus_raw / btn_minus_raw : raw asynchronous buttons, active-high
//   button_plus  / button_minus  : one-cycle increment / decrement pulses
//   held_plus    / held_minus    : debounced button levels
//   master : drives the raw buttons, observes the conditioned outputs
//   slave  : the conditioner itself
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
    logic btn_plus_raw;
    logic btn_minus_raw;
    logic button_plus;
    logic button_minus;
    logic held_plus;
    logic held_minus;

    modport master (
        output btn_plus_raw, btn_minus_raw,
        input  button_plus, button_minus, held_plus, held_minus
    );

    modport slave (
        input  btn_plus_raw, btn_minus_raw,
        output button_plus, button_minus, held_plus, held_minus
    );
endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : One button channel: two-flop synchronizer, debounce FSM
//               (IDLE / PRESS_WAIT / HELD / RELEASE_WAIT) with a saturating
//               16-bit stability counter, and an optional auto-repeat timer.
//   clk         : rising-edge clock
//   rst         : asynchronous reset, active-low
//   btn_raw     : raw asynchronous button, active-high
//   press_event : combinational, high in the cycle before an accepted press
//                 (or repeat) is registered by the parent
//   held        : debounced level, high in HELD or RELEASE_WAIT
// Build macro : BUTTON_CONDITIONER_AUTOREPEAT_EN enables the repeat timer.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btn_raw,
    output logic      press_event,
    output logic      held
);

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;

    // Only r_sync2 is allowed to feed logic; r_sync1 may be metastable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = sat_inc(r_cnt);
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = sat_inc(r_cnt);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign held = (r_state == ST_HELD) || (r_state == ST_RELEASE_WAIT);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_rpt_delay_last  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_rpt_period_last = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    logic             w_rpt_hit;

    // Counter is zero on the HELD entry edge, so hitting DELAY-1 lands the
    // registered repeat pulse exactly REPEAT_DELAY cycles after entry. A
    // repeat is only issued while the button is still seen pressed, so no
    // pulse coincides with leaving HELD.
    assign w_rpt_hit = (r_state == ST_HELD) && r_sync2 &&
                       (r_rpt_cnt == (r_rpt_first ? c_rpt_delay_last
                                                  : c_rpt_period_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (r_state != ST_HELD) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_hit) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt   <= sat_inc(r_rpt_cnt);
        end
    end

    assign press_event = w_accept | w_rpt_hit;
`else
    // Repeat parameters have no effect in this build.
    logic [63:0] w_unused_repeat_cfg;
    assign w_unused_repeat_cfg = {REPEAT_DELAY, REPEAT_PERIOD};

    assign press_event = w_accept;
`endif

endmodule : button_debounce
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions the plus / minus buttons for the segment display:
//               two independent debounce channels, net-zero suppression when
//               both would pulse in the same cycle, and registered pulses.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low
//   bus : button_conditioner_if.slave (raw buttons in; pulses and held
//         levels out)
// Parameters  : DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD (1..65535)
// Build macro : BUTTON_CONDITIONER_AUTOREPEAT_EN enables auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  wire logic           clk,
    input  wire logic           rst,
    button_conditioner_if.slave bus
);

    logic w_ev_plus;
    logic w_ev_minus;
    logic r_plus;
    logic r_minus;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_plus (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (bus.btn_plus_raw),
        .press_event (w_ev_plus),
        .held        (bus.held_plus)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_minus (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (bus.btn_minus_raw),
        .press_event (w_ev_minus),
        .held        (bus.held_minus)
    );

    // Coincident plus/minus events cancel each other. The ~r_* term keeps a
    // pulse from ever lasting two cycles even with 1-cycle repeat settings.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_plus  <= 1'b0;
            r_minus <= 1'b0;
        end else begin
            r_plus  <= w_ev_plus  & ~w_ev_minus & ~r_plus;
            r_minus <= w_ev_minus & ~w_ev_plus  & ~r_minus;
        end
    end

    assign bus.button_plus  = r_plus;
    assign bus.button_minus = r_minus;

endmodule : button_conditioner
`default_nettype wire
